dff_sipo_rx: RTL and testbench

Serial-to-parallel receiver: the reading end of a D-flip-flop serial bit chain. It samples a qualified serial stream, detects a start bit, shifts in WIDTH data bits LSB-first and presents the assembled word with a valid/acknowledge handshake. It sits downstream of any flip-flop-based serializer in the design. A dedicated shift register and an output holding register let the next frame arrive while the current word waits for the consumer.

---
 rtl/dff_sipo_rx_pkg.sv | 25 ++
 rtl/dff_sipo_rx_if.sv | 33 +++
 rtl/dff_sipo_rx_shift_reg.sv | 46 ++++
 rtl/dff_sipo_rx.sv | 159 +++++++++++++++
 tb/tb_dff_sipo_rx.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dff_sipo_rx_pkg.sv
// -----------------------------------------------------------------------------
// ff_pkg
// Shared definitions for the D-flip-flop serial chain blocks.
//   state_e        : receiver FSM encoding (ST_IDLE / ST_DATA / ST_PAR)
//   DEF_WIDTH      : default number of data bits per frame
//   par_odd_ones() : reduction helper used by the parity checker
// -----------------------------------------------------------------------------
package ff_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    // Returns 1 when the vector holds an odd number of ones. Under even
    // parity the data bits plus the parity bit must hold an even count,
    // so a 1 here is a parity error.
    function automatic logic par_odd_ones(input logic [32:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dff_sipo_rx_if.sv
// -----------------------------------------------------------------------------
// dff_sipo_rx_if
// Bundles the serial input, the consumer handshake and the status outputs of
// the serial-to-parallel receiver.
//   sd, se  : serial data bit and its bit enable
//   ack     : consumer accepts the word on q
//   q, vld  : received word and its valid flag
//   busy    : frame in progress
//   ovf     : sticky overrun flag
//   perr    : parity error for the word on q (only with PARITY_RX_EN)
// Modports: master = receiver (drives q/vld/status), slave = consumer/source.
// Optional feature macro: PARITY_RX_EN.
// -----------------------------------------------------------------------------
interface dff_sipo_rx_if #(
    parameter int WIDTH = ff_pkg::DEF_WIDTH
);
    logic             sd;
    logic             se;
    logic             ack;
    logic [WIDTH-1:0] q;
    logic             vld;
    logic             busy;
    logic             ovf;
`ifdef PARITY_RX_EN
    logic             perr;

    modport master (input sd, se, ack, output q, vld, busy, ovf, perr);
    modport slave  (output sd, se, ack, input q, vld, busy, ovf, perr);
`else
    modport master (input sd, se, ack, output q, vld, busy, ovf);
    modport slave  (output sd, se, ack, input q, vld, busy, ovf);
`endif
endinterface

// File: rtl/dff_sipo_rx_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
// WIDTH-bit right-shift register: on an enabled edge the serial bit enters
// the MSB and every other bit moves one place toward bit 0, so after WIDTH
// shifts bit 0 holds the first bit received.
//   c          : clock (rising edge)
//   rs         : asynchronous active-low clear
//   shift_en_i : shift enable
//   sd_i       : serial bit entering the MSB
//   data_o     : register contents
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             c,
    input  logic             rs,
    input  logic             shift_en_i,
    input  logic             sd_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next value: shift right when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (shift_en_i) begin
            data_d = {sd_i, data_q[WIDTH-1:1]};
        end else begin
            data_d = data_q;
        end
    end

    // Shift register state with asynchronous clear.
    always_ff @(posedge c or negedge rs) begin
        if (!rs) begin
            data_q <= {WIDTH{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/dff_sipo_rx.sv
// -----------------------------------------------------------------------------
// dff_sipo_rx
// Serial-to-parallel receiver at the reading end of a flip-flop bit chain.
// Waits for a start bit (sd=0 on an enabled edge), shifts in WIDTH data bits
// LSB-first (optionally followed by an even-parity bit) and presents the word
// on q with a valid/ack handshake. A separate shift register and output
// holding register let the next frame arrive while the current word waits.
//   c   : clock (rising edge)
//   rs  : asynchronous active-low reset
//   rx  : dff_sipo_rx_if.master (sd, se, ack in; q, vld, busy, ovf, perr out)
// Optional feature macro: PARITY_RX_EN (adds the PAR state and perr output).
// -----------------------------------------------------------------------------
module dff_sipo_rx
    import ff_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            c,
    input  logic            rs,
    dff_sipo_rx_if.master   rx
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_e           state_q;
    state_e           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             shift_en_s;
    logic             done_s;
    logic [WIDTH-1:0] sh_s;
    logic [WIDTH-1:0] word_s;
    logic             perr_calc_s;

    logic [WIDTH-1:0] q_q;
    logic             vld_q;
    logic             busy_q;
    logic             ovf_q;
    logic             perr_q;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .c          (c),
        .rs         (rs),
        .shift_en_i (shift_en_s),
        .sd_i       (rx.sd),
        .data_o     (sh_s)
    );

    // Frame FSM: next state, bit counter, shift enable and completion strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_en_s = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx.se && !rx.sd) begin
                    state_d = ST_DATA;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx.se) begin
                    shift_en_s = 1'b1;
                    cnt_d      = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_IDX) begin
`ifdef PARITY_RX_EN
                        state_d = ST_PAR;
`else
                        state_d = ST_IDLE;
                        done_s  = 1'b1;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef PARITY_RX_EN
            ST_PAR: begin
                if (rx.se) begin
                    state_d = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_d = ST_PAR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Assembled word: when the last data bit completes the frame it has not
    // reached the shift register yet, so it is merged in here; from PAR the
    // shift register already holds the whole word.
    always_comb begin
        word_s = sh_s;
        if (state_q == ST_DATA) begin
            word_s = {rx.sd, sh_s[WIDTH-1:1]};
        end else begin
            word_s = sh_s;
        end
    end

`ifdef PARITY_RX_EN
    // In PAR, sd is the parity bit being sampled on the completing edge.
    assign perr_calc_s = par_odd_ones(33'({word_s, rx.sd}));
`else
    assign perr_calc_s = 1'b0;
`endif

    // State, counter and output holding registers with the handshake rules.
    always_ff @(posedge c or negedge rs) begin
        if (!rs) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            q_q     <= {WIDTH{1'b0}};
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
            if (done_s) begin
                // A held word is replaced only if it is being accepted now.
                if (!vld_q || rx.ack) begin
                    q_q    <= word_s;
                    vld_q  <= 1'b1;
                    perr_q <= perr_calc_s;
                end else begin
                    ovf_q  <= 1'b1;
                end
            end else if (rx.ack && vld_q) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign rx.q    = q_q;
    assign rx.vld  = vld_q;
    assign rx.busy = busy_q;
    assign rx.ovf  = ovf_q;
`ifdef PARITY_RX_EN
    assign rx.perr = perr_q;
`endif

endmodule

// File: tb/tb_dff_sipo_rx.sv
// -----------------------------------------------------------------------------
// tb_dff_sipo_rx
// Directed bench for dff_sipo_rx (WIDTH=8). The driver pushes the expected
// word for every frame that should be presented; a monitor pops and compares
// whenever the DUT presents a new word (vld rising, or vld held while the
// previous edge carried ack). Direct checks cover reset, busy, ovf and vld.
// Build with PARITY_RX_EN defined to exercise the parity checks.
// -----------------------------------------------------------------------------
module tb_dff_sipo_rx;
    import ff_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] word;
        logic         perr;
    } exp_t;

    logic c  = 1'b0;
    logic rs = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic vld_prev = 1'b0;
    logic ack_seen = 1'b0;
    logic perr_mon;

    dff_sipo_rx_if #(.WIDTH(W)) rx_if ();

    dff_sipo_rx #(.WIDTH(W)) dut (
        .c  (c),
        .rs (rs),
        .rx (rx_if.master)
    );

`ifdef PARITY_RX_EN
    assign perr_mon = rx_if.perr;
`else
    assign perr_mon = 1'b0;
`endif

    always #5 c = ~c;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ack as it was sampled by the DUT on the last rising edge.
    always @(posedge c) ack_seen <= rx_if.ack;

    // Scoreboard monitor: compare each newly presented word.
    always @(negedge c) begin
        if (rs && rx_if.vld && (!vld_prev || ack_seen)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", rx_if.q);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_q", 32'(rx_if.q), 32'(mon_e.word));
`ifdef PARITY_RX_EN
                check("word_perr", 32'(perr_mon), 32'(mon_e.perr));
`endif
            end
        end
        vld_prev = rx_if.vld;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic se, input logic sd, input logic ack);
        rx_if.se  = se;
        rx_if.sd  = sd;
        rx_if.ack = ack;
        @(posedge c);
        #1;
    endtask

    // Start bit, WIDTH data bits LSB-first, then parity bit (or an idle
    // disabled edge without parity). ack_last raises ack on the completing edge.
    task automatic send_frame(input logic [W-1:0] w, input logic par_bit,
                              input bit stall, input bit ack_last);
        tick(1'b1, 1'b0, 1'b0);
        check("busy_after_start", 32'(rx_if.busy), 32'd1);
        for (int i = 0; i < W; i++) begin
            if (stall) tick(1'b0, ~w[i], 1'b0);
`ifdef PARITY_RX_EN
            tick(1'b1, w[i], 1'b0);
`else
            tick(1'b1, w[i], (i == W - 1) ? logic'(ack_last) : 1'b0);
`endif
        end
`ifdef PARITY_RX_EN
        if (stall) tick(1'b0, ~par_bit, 1'b0);
        tick(1'b1, par_bit, logic'(ack_last));
`else
        tick(1'b0, par_bit, 1'b0);
`endif
        rx_if.ack = 1'b0;
        rx_if.se  = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w1;
        rx_if.sd  = 1'b0;
        rx_if.se  = 1'b0;
        rx_if.ack = 1'b0;

        // Reset state.
        #12;
        check("rst_q",    32'(rx_if.q),    32'd0);
        check("rst_vld",  32'(rx_if.vld),  32'd0);
        check("rst_busy", 32'(rx_if.busy), 32'd0);
        check("rst_ovf",  32'(rx_if.ovf),  32'd0);
        check("rst_perr", 32'(perr_mon),   32'd0);
        @(negedge c);
        rs = 1'b1;

        // Line idles high: no frame.
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0);
        check("idle_busy", 32'(rx_if.busy), 32'd0);
        check("idle_vld",  32'(rx_if.vld),  32'd0);

        // Single frame: bits 1,0,1,1,0,0,1,0 -> 8'h4D.
        w1 = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_q.push_back('{word: 8'h4D, perr: 1'b0});
        send_frame(w1, 1'b0, 1'b0, 1'b0);
        check("f1_busy", 32'(rx_if.busy), 32'd0);
        check("f1_vld",  32'(rx_if.vld),  32'd1);
        tick(1'b0, 1'b1, 1'b1);
        check("f1_ack_vld", 32'(rx_if.vld), 32'd0);
        check("f1_ack_q",   32'(rx_if.q),   32'h4D);

        // Same frame with a stall edge before every bit.
        exp_q.push_back('{word: 8'h4D, perr: 1'b0});
        send_frame(w1, 1'b0, 1'b1, 1'b0);
        check("stall_vld", 32'(rx_if.vld), 32'd1);
        tick(1'b0, 1'b1, 1'b1);
        check("stall_ack_vld", 32'(rx_if.vld), 32'd0);

        // Ack on the completing edge replaces the held word without overrun.
        exp_q.push_back('{word: 8'hA5, perr: 1'b0});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{word: 8'h3C, perr: 1'b0});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check("ackc_q",   32'(rx_if.q),   32'h3C);
        check("ackc_vld", 32'(rx_if.vld), 32'd1);
        check("ackc_ovf", 32'(rx_if.ovf), 32'd0);
        tick(1'b0, 1'b1, 1'b1);
        check("ackc_ack_vld", 32'(rx_if.vld), 32'd0);

        // Overrun: second word discarded, ovf sticky.
        exp_q.push_back('{word: 8'hA5, perr: 1'b0});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("ovr_q",   32'(rx_if.q),   32'hA5);
        check("ovr_vld", 32'(rx_if.vld), 32'd1);
        check("ovr_ovf", 32'(rx_if.ovf), 32'd1);
        tick(1'b0, 1'b1, 1'b1);
        check("ovr_ack_vld", 32'(rx_if.vld), 32'd0);
        check("ovr_ack_ovf", 32'(rx_if.ovf), 32'd1);

`ifdef PARITY_RX_EN
        // Even parity: 8'h4D has four ones.
        exp_q.push_back('{word: 8'h4D, perr: 1'b0});
        send_frame(8'h4D, 1'b0, 1'b0, 1'b0);
        check("par_ok", 32'(perr_mon), 32'd0);
        tick(1'b0, 1'b1, 1'b1);
        exp_q.push_back('{word: 8'h4D, perr: 1'b1});
        send_frame(8'h4D, 1'b1, 1'b0, 1'b0);
        check("par_err", 32'(perr_mon), 32'd1);
        tick(1'b0, 1'b1, 1'b1);
`endif

        // Reset mid-frame discards everything, including the word held on q.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("mid_busy_pre", 32'(rx_if.busy), 32'd1);
        rs = 1'b0;
        #1;
        check("mid_busy", 32'(rx_if.busy), 32'd0);
        check("mid_q",    32'(rx_if.q),    32'd0);
        check("mid_vld",  32'(rx_if.vld),  32'd0);
        check("mid_ovf",  32'(rx_if.ovf),  32'd0);
        @(negedge c);
        rs = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        check("mid_after_busy", 32'(rx_if.busy), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
